// File: rtl/dma_channel_regfile_pkg.sv
// Shared types for the DMA channel register file: register selects and the
// per-channel mode layout.
package dma_pkg;

    localparam int MODE_W = 6;

    typedef enum logic [3:0] {
        REG_ADDR        = 4'd0,
        REG_COUNT       = 4'd1,
        REG_CMD         = 4'd2,
        REG_MODE        = 4'd3,
        REG_MASK_SINGLE = 4'd4,
        REG_MASK_ALL    = 4'd5,
        REG_REQ         = 4'd6,
        REG_STATUS      = 4'd7,
        REG_STATUS_HI   = 4'd8,
        REG_TEMP        = 4'd9,
        REG_CLR_PTR     = 4'd10,
        REG_MASTER_CLR  = 4'd11
    } reg_sel_e;

    typedef struct packed {
        logic [1:0] mode;
        logic [1:0] xfer_type;
        logic       decrement;
        logic       autoinit;
    } mode_t;

    function automatic int unsigned max_nb(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dma_channel_regfile_if.sv
// Program-mode byte bus between the CPU bus decode (master) and the
// register file (slave).
interface dma_channel_regfile_if #(
    parameter int NUM_CH = 4
) ();
    localparam int CH_W = $clog2(NUM_CH);

    logic            PROG_WE;
    logic            PROG_RE;
    logic [3:0]      PROG_SEL;
    logic [CH_W-1:0] PROG_CH;
    logic [7:0]      PROG_WDATA;
    logic [7:0]      PROG_RDATA;

    modport master (
        output PROG_WE, PROG_RE, PROG_SEL, PROG_CH, PROG_WDATA,
        input  PROG_RDATA
    );

    modport slave (
        input  PROG_WE, PROG_RE, PROG_SEL, PROG_CH, PROG_WDATA,
        output PROG_RDATA
    );
endinterface

// File: rtl/dma_channel_regfile_chan_ctr.sv
// One channel's base/current address and word count: byte-wise programming,
// per-transfer step, wrap, terminal-count detect and base reload.
module dma_chan_ctr #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              addr_we_i,
    input  logic              cnt_we_i,
    input  logic [1:0]        byte_idx_i,
    input  logic [7:0]        wdata_i,
    input  logic              step_i,
    input  logic              dec_i,
    input  logic              reload_i,
    output logic [ADDR_W-1:0] cur_addr_o,
    output logic [CNT_W-1:0]  cur_cnt_o,
    output logic              tc_o
);
    localparam int unsigned NB_A = ADDR_W / 8;
    localparam int unsigned NB_C = CNT_W / 8;

    logic [ADDR_W-1:0] base_addr_q, base_addr_d;
    logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
    logic [CNT_W-1:0]  base_cnt_q,  base_cnt_d;
    logic [CNT_W-1:0]  cur_cnt_q,   cur_cnt_d;

    always_comb begin
        base_addr_d = base_addr_q;
        cur_addr_d  = cur_addr_q;
        base_cnt_d  = base_cnt_q;
        cur_cnt_d   = cur_cnt_q;
        tc_o        = step_i && (cur_cnt_q == '0);

        if (step_i) begin
            cur_addr_d = dec_i ? cur_addr_q - ADDR_W'(1) : cur_addr_q + ADDR_W'(1);
            cur_cnt_d  = cur_cnt_q - CNT_W'(1);
            if (tc_o && reload_i) begin
                cur_addr_d = base_addr_q;
                cur_cnt_d  = base_cnt_q;
            end
        end

        for (int unsigned b = 0; b < NB_A; b++) begin
            if (addr_we_i && (32'(byte_idx_i) == b)) begin
                base_addr_d[8*b +: 8] = wdata_i;
                cur_addr_d[8*b +: 8]  = wdata_i;
            end
        end
        for (int unsigned b = 0; b < NB_C; b++) begin
            if (cnt_we_i && (32'(byte_idx_i) == b)) begin
                base_cnt_d[8*b +: 8] = wdata_i;
                cur_cnt_d[8*b +: 8]  = wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            base_addr_q <= '0;
            cur_addr_q  <= '0;
            base_cnt_q  <= '0;
            cur_cnt_q   <= '0;
        end else begin
            base_addr_q <= base_addr_d;
            cur_addr_q  <= cur_addr_d;
            base_cnt_q  <= base_cnt_d;
            cur_cnt_q   <= cur_cnt_d;
        end
    end

    assign cur_addr_o = cur_addr_q;
    assign cur_cnt_o  = cur_cnt_q;

endmodule

// File: rtl/dma_channel_regfile.sv
// 8237-style DMA datapath register file for NUM_CH channels.
// Build option DMA_AUTOINIT_EN enables autoinitialise reload on terminal count.
module dma_channel_regfile
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                       CLOCK,
    input  logic                       RESET_N,
    dma_channel_regfile_if.slave       prog,
    input  logic                       XFER_STEP,
    input  logic [$clog2(NUM_CH)-1:0]  ACTIVE_CH,
    input  logic [NUM_CH-1:0]          DREQ_IN,
    output logic [ADDR_W-1:0]          CUR_ADDR,
    output logic                       TC,
    output logic [NUM_CH-1:0]          MASK_OUT,
    output logic [NUM_CH-1:0]          REQ_OUT,
    output logic [NUM_CH*MODE_W-1:0]   MODE_OUT,
    output logic [7:0]                 CMD_OUT
);
    localparam int          CH_W = $clog2(NUM_CH);
    localparam int unsigned NB_A = ADDR_W / 8;
    localparam int unsigned NB_C = CNT_W / 8;

    reg_sel_e          sel;
    logic              wr, rd, ac_sel, master_clr, prog_hits_active;
    logic [NUM_CH-1:0] addr_we, cnt_we, step_v, tc_evt;
    logic [ADDR_W-1:0] ch_addr [NUM_CH];
    logic [CNT_W-1:0]  ch_cnt  [NUM_CH];

    logic [1:0]        ptr_q, ptr_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] req_q, req_d;
    logic [NUM_CH-1:0] status_q, status_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        temp_q, temp_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              tc_q;
    mode_t             mode_q [NUM_CH];
    mode_t             mode_d [NUM_CH];

    mode_t             mode_wr;
    logic [CH_W-1:0]   mode_ch;
    logic [7:0]        tc_ext, dreq_ext;
    int unsigned       nb_sel;

    always_comb begin
        sel              = reg_sel_e'(prog.PROG_SEL);
        wr               = prog.PROG_WE;
        rd               = prog.PROG_RE && !prog.PROG_WE;
        ac_sel           = (sel == REG_ADDR) || (sel == REG_COUNT);
        master_clr       = wr && (sel == REG_MASTER_CLR);
        // A program write to the channel being serviced drops that step entirely
        prog_hits_active = wr && ac_sel && (prog.PROG_CH == ACTIVE_CH);
        addr_we = '0;
        cnt_we  = '0;
        step_v  = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            addr_we[c] = wr && (sel == REG_ADDR)  && (32'(prog.PROG_CH) == c);
            cnt_we[c]  = wr && (sel == REG_COUNT) && (32'(prog.PROG_CH) == c);
            step_v[c]  = XFER_STEP && !prog_hits_active && (32'(ACTIVE_CH) == c);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dma_chan_ctr #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_ctr (
            .clk_i      (CLOCK),
            .rst_ni     (RESET_N),
            .clr_i      (master_clr),
            .addr_we_i  (addr_we[c]),
            .cnt_we_i   (cnt_we[c]),
            .byte_idx_i (ptr_q),
            .wdata_i    (prog.PROG_WDATA),
            .step_i     (step_v[c]),
            .dec_i      (mode_q[c].decrement),
            .reload_i   (mode_q[c].autoinit),
            .cur_addr_o (ch_addr[c]),
            .cur_cnt_o  (ch_cnt[c]),
            .tc_o       (tc_evt[c])
        );
    end

    always_comb begin
        ptr_d    = ptr_q;
        mask_d   = mask_q;
        req_d    = req_q;
        status_d = status_q;
        cmd_d    = cmd_q;
        temp_d   = temp_q;
        rdata_d  = rdata_q;
        mode_d   = mode_q;

        tc_ext   = '0;
        tc_ext[NUM_CH-1:0] = status_q;
        dreq_ext = '0;
        dreq_ext[NUM_CH-1:0] = DREQ_IN;

        mode_wr = mode_t'(prog.PROG_WDATA[7:2]);
`ifndef DMA_AUTOINIT_EN
        mode_wr.autoinit = 1'b0;
`endif
        mode_ch = (NUM_CH > 4) ? prog.PROG_CH : prog.PROG_WDATA[CH_W-1:0];

        nb_sel = (sel == REG_ADDR) ? NB_A : NB_C;
        if ((wr || rd) && ac_sel) begin
            ptr_d = (32'(ptr_q) >= nb_sel - 1) ? '0 : ptr_q + 2'd1;
        end

        if (wr) begin
            case (sel)
                REG_CLR_PTR:     ptr_d = '0;
                REG_CMD:         cmd_d = prog.PROG_WDATA;
                REG_MODE:        if (32'(mode_ch) < NUM_CH) mode_d[mode_ch] = mode_wr;
                REG_MASK_SINGLE: mask_d[prog.PROG_CH] = prog.PROG_WDATA[2];
                REG_MASK_ALL:    mask_d = prog.PROG_WDATA[NUM_CH-1:0];
                REG_REQ:         req_d[prog.PROG_CH] = prog.PROG_WDATA[2];
                default:         ;
            endcase
        end

        if (rd) begin
            case (sel)
                REG_ADDR:      rdata_d = 8'(ch_addr[prog.PROG_CH] >> (8 * ptr_q));
                REG_COUNT:     rdata_d = 8'(ch_cnt[prog.PROG_CH] >> (8 * ptr_q));
                REG_STATUS:    rdata_d = {dreq_ext[3:0], tc_ext[3:0]};
                REG_STATUS_HI: rdata_d = {dreq_ext[7:4], tc_ext[7:4]};
                REG_TEMP:      rdata_d = temp_q;
                default:       rdata_d = '0;
            endcase
        end

        // A TC landing on the same edge as a status read survives the clear
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (rd && (sel == REG_STATUS) && (c < 4))     status_d[c] = 1'b0;
            if (rd && (sel == REG_STATUS_HI) && (c >= 4)) status_d[c] = 1'b0;
            if (tc_evt[c]) begin
                status_d[c] = 1'b1;
                req_d[c]    = 1'b0;
                if (!mode_q[c].autoinit) mask_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N || master_clr) begin
            ptr_q    <= '0;
            mask_q   <= '1;
            req_q    <= '0;
            status_q <= '0;
            cmd_q    <= '0;
            temp_q   <= '0;
            rdata_q  <= '0;
            tc_q     <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) mode_q[c] <= '0;
        end else begin
            ptr_q    <= ptr_d;
            mask_q   <= mask_d;
            req_q    <= req_d;
            status_q <= status_d;
            cmd_q    <= cmd_d;
            temp_q   <= temp_d;
            rdata_q  <= rdata_d;
            tc_q     <= |tc_evt;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        MODE_OUT = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) MODE_OUT[c*MODE_W +: MODE_W] = mode_q[c];
    end

    assign prog.PROG_RDATA = rdata_q;
    assign CUR_ADDR        = ch_addr[ACTIVE_CH];
    assign TC              = tc_q;
    assign MASK_OUT        = mask_q;
    assign REQ_OUT         = req_q;
    assign CMD_OUT         = cmd_q;

endmodule

// File: tb/tb_dma_channel_regfile.sv
// Directed bench: a 4-channel/16-bit instance and an 8-channel/24-bit instance.
module tb_dma_channel_regfile;
    import dma_pkg::*;

    logic CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;
    logic RESET_N;

    dma_channel_regfile_if #(.NUM_CH(4)) p0 ();
    dma_channel_regfile_if #(.NUM_CH(8)) p1 ();

    logic        xs0, xs1, tc0, tc1;
    logic [1:0]  ac0;
    logic [2:0]  ac1;
    logic [3:0]  dreq0, mask0, req0;
    logic [7:0]  dreq1, mask1, req1, cmd0, cmd1;
    logic [15:0] cur0;
    logic [23:0] cur1;
    logic [23:0] mode0;
    logic [47:0] mode1;

    dma_channel_regfile #(.NUM_CH(4), .ADDR_W(16), .CNT_W(16)) u0 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .prog(p0), .XFER_STEP(xs0), .ACTIVE_CH(ac0),
        .DREQ_IN(dreq0), .CUR_ADDR(cur0), .TC(tc0), .MASK_OUT(mask0), .REQ_OUT(req0),
        .MODE_OUT(mode0), .CMD_OUT(cmd0)
    );

    dma_channel_regfile #(.NUM_CH(8), .ADDR_W(24), .CNT_W(16)) u1 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .prog(p1), .XFER_STEP(xs1), .ACTIVE_CH(ac1),
        .DREQ_IN(dreq1), .CUR_ADDR(cur1), .TC(tc1), .MASK_OUT(mask1), .REQ_OUT(req1),
        .MODE_OUT(mode1), .CMD_OUT(cmd1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic we, input logic re, input reg_sel_e sel,
                         input int ch, input logic [7:0] data);
        if (d == 0) begin
            p0.PROG_WE = we; p0.PROG_RE = re; p0.PROG_SEL = sel;
            p0.PROG_CH = 2'(ch); p0.PROG_WDATA = data;
        end else begin
            p1.PROG_WE = we; p1.PROG_RE = re; p1.PROG_SEL = sel;
            p1.PROG_CH = 3'(ch); p1.PROG_WDATA = data;
        end
    endtask

    task automatic idle();
        p0.PROG_WE = 1'b0; p0.PROG_RE = 1'b0;
        p1.PROG_WE = 1'b0; p1.PROG_RE = 1'b0;
    endtask

    task automatic wr(input int d, input reg_sel_e sel, input int ch, input logic [7:0] data);
        @(negedge CLOCK);
        drive(d, 1'b1, 1'b0, sel, ch, data);
        @(negedge CLOCK);
        idle();
    endtask

    task automatic rdchk(input int d, input reg_sel_e sel, input int ch,
                         input logic [7:0] exp, input string tag);
        @(negedge CLOCK);
        drive(d, 1'b0, 1'b1, sel, ch, 8'h00);
        @(negedge CLOCK);
        idle();
        check_eq(tag, (d == 0) ? p0.PROG_RDATA : p1.PROG_RDATA, exp);
    endtask

    task automatic step(input int d, input int ch);
        @(negedge CLOCK);
        if (d == 0) begin xs0 = 1'b1; ac0 = 2'(ch); end
        else        begin xs1 = 1'b1; ac1 = 3'(ch); end
        @(negedge CLOCK);
        xs0 = 1'b0; xs1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        RESET_N = 1'b0;
        xs0 = 1'b0; xs1 = 1'b0; ac0 = '0; ac1 = '0; dreq0 = '0; dreq1 = '0;
        drive(0, 1'b0, 1'b0, REG_ADDR, 0, 8'h00);
        drive(1, 1'b0, 1'b0, REG_ADDR, 0, 8'h00);
        repeat (3) @(negedge CLOCK);
        RESET_N = 1'b1;

        // reset state
        check_eq("rst_mask0", mask0, 4'hF);
        check_eq("rst_mask1", mask1, 8'hFF);
        check_eq("rst_tc", tc0, 1'b0);
        check_eq("rst_cmd", cmd0, 8'h00);
        check_eq("rst_mode", mode0, 24'h0);
        check_eq("rst_req", req0, 4'h0);
        check_eq("rst_rdata", p0.PROG_RDATA, 8'h00);
        rdchk(0, REG_STATUS, 0, 8'h00, "rst_status");
        rdchk(0, REG_ADDR, 0, 8'h00, "rst_addr_b0");
        rdchk(0, REG_ADDR, 0, 8'h00, "rst_addr_b1");
        rdchk(0, REG_COUNT, 0, 8'h00, "rst_cnt_b0");

        // byte-wise address programming and readback
        wr(0, REG_CLR_PTR, 0, 8'h00);
        wr(0, REG_ADDR, 2, 8'h34);
        wr(0, REG_ADDR, 2, 8'h12);
        rdchk(0, REG_ADDR, 2, 8'h34, "a2_b0");
        rdchk(0, REG_ADDR, 2, 8'h12, "a2_b1");
        ac0 = 2'd2; #1;
        check_eq("a2_cur", cur0, 16'h1234);

        // increment transfers, TC on the step from count 0
        wr(0, REG_COUNT, 1, 8'h02);
        wr(0, REG_COUNT, 1, 8'h00);
        wr(0, REG_MODE, 0, 8'h01);
        wr(0, REG_ADDR, 1, 8'hFF);
        wr(0, REG_ADDR, 1, 8'h00);
        wr(0, REG_MASK_SINGLE, 1, 8'h00);
        check_eq("unmask1", mask0, 4'b1101);
        wr(0, REG_REQ, 1, 8'h04);
        check_eq("req1_set", req0, 4'b0010);
        check_eq("mode1", mode0[11:6], 6'h00);
        step(0, 1);
        check_eq("s1_addr", cur0, 16'h0100);
        check_eq("s1_tc", tc0, 1'b0);
        step(0, 1);
        check_eq("s2_addr", cur0, 16'h0101);
        check_eq("s2_tc", tc0, 1'b0);
        step(0, 1);
        check_eq("s3_addr", cur0, 16'h0102);
        check_eq("s3_tc", tc0, 1'b1);
        check_eq("s3_mask", mask0, 4'b1111);
        check_eq("s3_req", req0, 4'b0000);
        @(negedge CLOCK);
        check_eq("tc_pulse", tc0, 1'b0);
        dreq0 = 4'b0100;
        rdchk(0, REG_STATUS, 0, 8'h42, "st_tc1");
        rdchk(0, REG_STATUS, 0, 8'h40, "st_clr");
        dreq0 = 4'b0000;
        rdchk(0, REG_COUNT, 1, 8'hFF, "c1_b0");
        rdchk(0, REG_COUNT, 1, 8'hFF, "c1_b1");

        // autoinit + decrement from address 0, count 0
        wr(0, REG_MODE, 0, 8'h0C);
`ifdef DMA_AUTOINIT_EN
        check_eq("mode0", mode0[5:0], 6'h03);
`else
        check_eq("mode0", mode0[5:0], 6'h02);
`endif
        wr(0, REG_ADDR, 0, 8'h00);
        wr(0, REG_ADDR, 0, 8'h00);
        wr(0, REG_COUNT, 0, 8'h00);
        wr(0, REG_COUNT, 0, 8'h00);
        wr(0, REG_MASK_SINGLE, 0, 8'h00);
        check_eq("unmask0", mask0, 4'b1110);
        step(0, 0);
        check_eq("ai_tc", tc0, 1'b1);
`ifdef DMA_AUTOINIT_EN
        check_eq("ai_addr", cur0, 16'h0000);
        check_eq("ai_mask", mask0, 4'b1110);
        rdchk(0, REG_COUNT, 0, 8'h00, "ai_cnt_b0");
        rdchk(0, REG_COUNT, 0, 8'h00, "ai_cnt_b1");
`else
        check_eq("ai_addr", cur0, 16'hFFFF);
        check_eq("ai_mask", mask0, 4'b1111);
        rdchk(0, REG_COUNT, 0, 8'hFF, "ai_cnt_b0");
        rdchk(0, REG_COUNT, 0, 8'hFF, "ai_cnt_b1");
`endif
        rdchk(0, REG_STATUS, 0, 8'h01, "ai_status");

        wr(0, REG_MASK_ALL, 0, 8'h05);
        check_eq("mask_all", mask0, 4'b0101);
        wr(0, REG_CMD, 0, 8'hA5);
        check_eq("cmd", cmd0, 8'hA5);

        // program write and step on the same channel in the same cycle
        wr(0, REG_CLR_PTR, 0, 8'h00);
        @(negedge CLOCK);
        drive(0, 1'b1, 1'b0, REG_COUNT, 3, 8'h5A);
        xs0 = 1'b1; ac0 = 2'd3;
        @(negedge CLOCK);
        idle();
        xs0 = 1'b0;
        check_eq("cf_tc", tc0, 1'b0);
        check_eq("cf_addr", cur0, 16'h0000);
        wr(0, REG_COUNT, 3, 8'h00);
        rdchk(0, REG_COUNT, 3, 8'h5A, "cf_cnt_b0");
        rdchk(0, REG_COUNT, 3, 8'h00, "cf_cnt_b1");
        step(0, 3);
        check_eq("cf_step_addr", cur0, 16'h0001);
        check_eq("cf_step_tc", tc0, 1'b0);

        // 8 channels, 24-bit address
        wr(1, REG_CLR_PTR, 0, 8'h00);
        wr(1, REG_ADDR, 7, 8'hEF);
        wr(1, REG_ADDR, 7, 8'hCD);
        wr(1, REG_ADDR, 7, 8'hAB);
        ac1 = 3'd7; #1;
        check_eq("a7_cur", cur1, 24'hABCDEF);
        wr(1, REG_MODE, 7, 8'h08);
        check_eq("mode7", mode1[47:42], 6'h02);
        step(1, 7);
        check_eq("a7_tc", tc1, 1'b1);
        check_eq("a7_dec", cur1, 24'hABCDEE);
        dreq1 = 8'h20;
        rdchk(1, REG_STATUS_HI, 0, 8'h28, "sthi_tc7");
        rdchk(1, REG_STATUS, 0, 8'h00, "stlo_u1");
        rdchk(1, REG_STATUS_HI, 0, 8'h20, "sthi_clr");
        dreq1 = 8'h00;
        rdchk(1, REG_ADDR, 7, 8'hEE, "a7_b0");
        wr(1, REG_MASTER_CLR, 0, 8'h00);
        check_eq("mclr_mask", mask1, 8'hFF);
        check_eq("mclr_addr", cur1, 24'h0);
        check_eq("mclr_mode", mode1, 48'h0);

        // reset asserted during a transfer step
        @(negedge CLOCK);
        xs0 = 1'b1; ac0 = 2'd1; RESET_N = 1'b0;
        @(negedge CLOCK);
        xs0 = 1'b0; RESET_N = 1'b1;
        check_eq("rr_addr", cur0, 16'h0000);
        check_eq("rr_tc", tc0, 1'b0);
        check_eq("rr_mask", mask0, 4'hF);
        check_eq("rr_cmd", cmd0, 8'h00);
        check_eq("rr_req", req0, 4'h0);
        check_eq("rr_mode", mode0, 24'h0);
        check_eq("rr_rdata", p0.PROG_RDATA, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dma_channel_regfile.md
Name: dma_channel_regfile

Overview:
Parametrised successor to the 8237A-5 datapath register block: per-channel base/current address and word-count registers, plus mode, mask, request, command, status and temporary registers. NUM_CH channels, ADDR_W/CNT_W-bit registers, programmed a byte at a time through a multi-byte pointer. Sits between the CPU program-mode bus decode and the transfer-mode timing FSM. Adds address decrement, autoinitialise reload and per-transfer terminal count (TC) detection.

Parameters:
NUM_CH, 4, channel count (2..8); CH_W = $clog2(NUM_CH)
ADDR_W, 16, address register width (multiple of 8, 16..32)
CNT_W, 16, word-count register width (multiple of 8, 16..32)
NB_A/NB_C, derived, byte counts ADDR_W/8 and CNT_W/8

Ports:
CLOCK  in  1  system clock
RESET_N  in  1  synchronous active-low reset, sampled on posedge CLOCK
PROG_WE  in  1  program-mode byte write strobe (one cycle per byte)
PROG_RE  in  1  program-mode byte read strobe
PROG_SEL  in  4  register select (reg_sel_e)
PROG_CH  in  CH_W  target channel for ADDR/COUNT/MODE
PROG_WDATA  in  8  write byte
PROG_RDATA  out  8  read byte, registered
XFER_STEP  in  1  one transfer completed on ACTIVE_CH
ACTIVE_CH  in  CH_W  channel currently serviced
DREQ_IN  in  NUM_CH  synchronised DREQ lines, for status
CUR_ADDR  out  ADDR_W  current address of ACTIVE_CH (combinational)
TC  out  1  terminal-count pulse, one cycle
MASK_OUT  out  NUM_CH  mask register
REQ_OUT  out  NUM_CH  software request register
MODE_OUT  out  NUM_CH*6  mode registers, packed
CMD_OUT  out  8  command register

Behaviour:
- Reset (RESET_N=0) or MASTER_CLR write: base/current address and count = 0, mode = 0, command = 0, request = 0, status = 0, temp = 0, byte pointer = 0, MASK_OUT = all 1, PROG_RDATA = 0, TC = 0. Reset dominates any same-cycle strobe.
- Byte pointer: 0..max(NB_A,NB_C)-1; LSB first. Each ADDR/COUNT access increments it, wrapping to 0 after byte NB-1 of the selected register. CLR_PTR write forces 0.
- ADDR write: byte[ptr] written to both base and current address of PROG_CH; COUNT likewise. Other bytes unchanged.
- ADDR/COUNT read: PROG_RDATA <= current register byte[ptr] one cycle after PROG_RE. STATUS read returns {DREQ status[3:0], TC bits[3:0]} for channels 0..3 (channels 4..7 status on STATUS_HI select), then clears TC bits of the returned half. TEMP read returns temp.
- MODE write: PROG_WDATA[7:2] -> mode[PROG_WDATA[CH_W-1:0]]; for NUM_CH>4, bits come from PROG_CH. Mode bits: [0] autoinit, [1] decrement, [3:2] xfer type, [5:4] mode.
- MASK_SINGLE: bit PROG_WDATA[2] value into MASK[PROG_CH]. MASK_ALL: MASK <= PROG_WDATA[NUM_CH-1:0]. REQ likewise on bit[PROG_CH].
- XFER_STEP on channel c: current addr +1, or -1 if mode[c].decrement, modulo 2^ADDR_W. Count -1 modulo 2^CNT_W.
- TC: asserted the cycle after an XFER_STEP where count was 0 before the step (0 -> all-ones). Sets status TC[c], clears REQ[c]. If autoinit: current addr/count <= base in the same edge. Otherwise MASK[c] <= 1.
- Simultaneous PROG_WE and XFER_STEP to the same channel/register: program write wins; the step is dropped and TC is not generated.
- PROG_WE and PROG_RE together: write only, pointer advances once.

Optional Feature:
DMA_AUTOINIT_EN: when defined, autoinit reload as above. When undefined, mode bit[0] reads back 0, the base registers are still written but never reloaded, and TC always sets MASK[c].

Decomposition:
- Package dma_pkg: reg_sel_e (ADDR, COUNT, CMD, MODE, MASK_SINGLE, MASK_ALL, REQ, STATUS, STATUS_HI, TEMP, CLR_PTR, MASTER_CLR), mode_t packed struct, MODE_W=6 constant.
- One sub-module, dma_chan_ctr: a single channel's base/current address/count, step, wrap and reload; instantiated NUM_CH times via generate.

Test Plan:
- Reset, then read all registers -> MASK_OUT=4'hF, STATUS read 8'h00, address/count bytes 0.
- CLR_PTR; write ADDR ch2 bytes 34h, 12h; read back -> 34h, 12h. Base addr[2]=1234h.
- Count ch1=0002h, increment mode, addr 00FFh; three XFER_STEPs -> CUR_ADDR 0100h, 0101h, 0102h. TC after third step; MASK[1]=1; STATUS bit1=1, cleared after read.
- Autoinit + decrement, ch0 addr 0000h, count 0000h; one step -> addr wraps to FFFFh, TC=1. Current reloaded to base 0000h/0000h (feature on); no reload, MASK[0]=1 (feature off).
- NUM_CH=8, ADDR_W=24: write three address bytes on ch7 -> CUR_ADDR=ABCDEFh. STATUS_HI shows TC[7] after TC.
- Same-cycle COUNT write and XFER_STEP on ch3 -> written byte held, no decrement, TC=0. RESET_N low mid-transfer -> all registers at reset values next edge.
